// File: rtl/bb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bb_pkg
// Description : Shared constants, header field positions, command and state
//               encodings for the baseband RAM bank loader.
//               Optional build macro BB_LOADER_TIMEOUT_EN adds the PAD state.
// Revision    : 1.0 - initial release
// ============================================================================
package bb_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         CA_WORDS  = 32;
  localparam int         MSG_WORDS = 47;
  localparam int         DELAY_W   = 10;

  // Word counter must hold the largest burst index.
  localparam int             CNT_W    = 6;
  localparam logic [CNT_W-1:0] CA_LAST  = CNT_W'(CA_WORDS - 1);
  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_WORDS - 1);

  // Header field bit positions.
  localparam int SYNC_MSB = 31;
  localparam int SYNC_LSB = 24;
  localparam int CMD_MSB  = 21;
  localparam int CMD_LSB  = 20;
  localparam int CH_MSB   = 18;
  localparam int CH_LSB   = 16;
  localparam int DLY_MSB  = 9;
  localparam int DLY_LSB  = 0;

  typedef enum logic [1:0] {
    CMD_CA  = 2'd0,
    CMD_MSG = 2'd1,
    CMD_DLY = 2'd2,
    CMD_RSV = 2'd3
  } cmd_e;

`ifdef BB_LOADER_TIMEOUT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PAD  = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1
  } state_e;
`endif

  // One-hot write enable for a 4-bit RAM index (CA 0-7, MSG 8-15).
  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bb_hdr_decode.sv
`default_nettype none
// ============================================================================
// Module      : bb_hdr_decode
// Description : Combinational header field extraction and validity check
//               (sync byte match, command not reserved).
// Revision    : 1.0 - initial release
// ============================================================================
module bb_hdr_decode
  import bb_pkg::*;
(
  input  logic [31:0]        hdr,
  output logic               hdr_ok,
  output cmd_e               cmd,
  output logic [2:0]         ch,
  output logic [DELAY_W-1:0] dly
);

  logic sync_ok;
  logic unused_bits;

  assign sync_ok = (hdr[SYNC_MSB:SYNC_LSB] == SYNC_BYTE);
  assign cmd     = cmd_e'(hdr[CMD_MSB:CMD_LSB]);
  assign ch      = hdr[CH_MSB:CH_LSB];
  assign dly     = hdr[DLY_MSB:DLY_LSB];
  assign hdr_ok  = sync_ok && (cmd != CMD_RSV);

  // Reserved header bits carry no meaning and are ignored.
  assign unused_bits = ^{hdr[SYNC_LSB-1:CMD_MSB+1],
                         hdr[CMD_LSB-1:CH_MSB+1],
                         hdr[CH_LSB-1:DLY_MSB+1]};

endmodule
`default_nettype wire

// File: rtl/bb_loader.sv
`default_nettype none
// ============================================================================
// Module      : bb_loader
// Description : Parses the 32-bit USB3 word stream into command headers,
//               routes payload bursts to one of 16 baseband RAMs through a
//               registered data bus and one-hot write enable, and holds the
//               eight per-channel code delay registers.
//               Build macro BB_LOADER_TIMEOUT_EN: stalled bursts time out and
//               are padded with zero words so the bank address stays aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module bb_loader
  import bb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [31:0]            data,
  output logic [15:0]            wren,
  output logic [8*DELAY_W-1:0]   delay_ca,
  output logic                   busy,
  output logic                   err
);

  state_e               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [CNT_W-1:0]     last, last_n;
  logic [3:0]           target, target_n;
  logic [31:0]          data_n;
  logic [15:0]          wren_n;
  logic [8*DELAY_W-1:0] delay_n;
  logic                 busy_n;
  logic                 err_n;
  logic                 accept;

  logic                 hdr_ok;
  cmd_e                 cmd;
  logic [2:0]           ch;
  logic [DELAY_W-1:0]   dly;

`ifdef BB_LOADER_TIMEOUT_EN
  logic [15:0]          idle_cnt, idle_n;
  assign s_ready = (state != ST_PAD);
`else
  assign s_ready = 1'b1;
`endif

  assign accept = s_valid && s_ready;

  bb_hdr_decode u_hdr_decode (
    .hdr    (s_data),
    .hdr_ok (hdr_ok),
    .cmd    (cmd),
    .ch     (ch),
    .dly    (dly)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state and next-output logic; payload words bypass the decoder entirely.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    last_n   = last;
    target_n = target;
    data_n   = data;
    wren_n   = '0;
    delay_n  = delay_ca;
    busy_n   = busy;
    err_n    = 1'b0;
`ifdef BB_LOADER_TIMEOUT_EN
    idle_n   = idle_cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!hdr_ok) begin
            err_n = 1'b1;
          end else if (cmd == CMD_DLY) begin
            delay_n[int'(ch)*DELAY_W +: DELAY_W] = dly;
          end else begin
            target_n = {cmd == CMD_MSG, ch};
            last_n   = (cmd == CMD_MSG) ? MSG_LAST : CA_LAST;
            cnt_n    = '0;
            busy_n   = 1'b1;
            state_n  = ST_LOAD;
`ifdef BB_LOADER_TIMEOUT_EN
            idle_n   = '0;
`endif
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          data_n = s_data;
          wren_n = onehot16(target);
          cnt_n  = cnt + 1'b1;
`ifdef BB_LOADER_TIMEOUT_EN
          idle_n = '0;
`endif
          if (cnt == last) begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
          end
        end
`ifdef BB_LOADER_TIMEOUT_EN
        else if (idle_cnt == 16'hFFFF) begin
          err_n   = 1'b1;
          state_n = ST_PAD;
        end else begin
          idle_n = idle_cnt + 16'd1;
        end
`endif
      end
`ifdef BB_LOADER_TIMEOUT_EN
      // Fill the rest of the burst with zeros to keep the bank address aligned.
      ST_PAD: begin
        data_n = '0;
        wren_n = onehot16(target);
        cnt_n  = cnt + 1'b1;
        if (cnt == last) begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
        end
      end
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  // Datapath, counters and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      last     <= '0;
      target   <= '0;
      data     <= '0;
      wren     <= '0;
      delay_ca <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
`ifdef BB_LOADER_TIMEOUT_EN
      idle_cnt <= '0;
`endif
    end else begin
      cnt      <= cnt_n;
      last     <= last_n;
      target   <= target_n;
      data     <= data_n;
      wren     <= wren_n;
      delay_ca <= delay_n;
      busy     <= busy_n;
      err      <= err_n;
`ifdef BB_LOADER_TIMEOUT_EN
      idle_cnt <= idle_n;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bb_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bb_loader
// Description : Self-checking bench for bb_loader: directed scenarios plus
//               randomized transaction sequences against a transaction-level
//               reference model. BB_LOADER_TIMEOUT_EN enables the pad test.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bb_loader;

  localparam int DW = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] data;
  logic [15:0] wren;
  logic [8*DW-1:0] delay_ca;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;

  // Reference model state: delay registers and last written data word.
  logic [DW-1:0] dly_m [8];
  logic [31:0]   last_data;

  bb_loader dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .data     (data),
    .wren     (wren),
    .delay_ca (delay_ca),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] dly_pack();
    logic [79:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) p[i*DW +: DW] = dly_m[i];
    return p;
  endfunction

  // Drive one cycle of input, then sample just after the rising edge.
  task automatic step(input logic v, input logic [31:0] w);
    s_valid = v;
    s_data  = w;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, $urandom);
      chk("idle_wren", 80'(wren), 80'h0);
      chk("idle_err", 80'(err), 80'h0);
      chk("idle_busy", 80'(busy), 80'h0);
    end
  endtask

  // mode: 0 = no gaps, 1 = one gap between words, 2 = random gaps.
  // nwords < full length leaves the burst open (used for reset tests).
  task automatic run_burst(input bit msg, input logic [2:0] ch, input int mode,
                           input bit seq, input int nwords);
    logic [31:0] hdr;
    logic [15:0] oh;
    logic [31:0] w;
    int          n;
    int          gaps;
    n   = msg ? 47 : 32;
    hdr = $urandom;
    hdr[31:24] = 8'hA5;
    hdr[21:20] = msg ? 2'd1 : 2'd0;
    hdr[18:16] = ch;
    oh  = 16'(1) << (int'(ch) + (msg ? 8 : 0));
    step(1'b1, hdr);
    chk("hdr_wren", 80'(wren), 80'h0);
    chk("hdr_busy", 80'(busy), 80'h1);
    chk("hdr_err", 80'(err), 80'h0);
    for (int i = 0; i < nwords; i++) begin
      gaps = (mode == 1 && i > 0) ? 1 :
             (mode == 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
      for (int g = 0; g < gaps; g++) begin
        step(1'b0, $urandom);
        chk("gap_wren", 80'(wren), 80'h0);
        chk("gap_data", 80'(data), 80'(last_data));
        chk("gap_busy", 80'(busy), 80'h1);
      end
      w = seq ? 32'(i) : $urandom;
      step(1'b1, w);
      chk("ld_wren", 80'(wren), 80'(oh));
      chk("ld_data", 80'(data), 80'(w));
      chk("ld_busy", 80'(busy), (i == n - 1) ? 80'h0 : 80'h1);
      chk("ld_err", 80'(err), 80'h0);
      chk("ld_ready", 80'(s_ready), 80'h1);
      last_data = w;
    end
  endtask

  task automatic run_delay(input logic [2:0] ch, input logic [DW-1:0] d);
    logic [31:0] hdr;
    hdr = $urandom;
    hdr[31:24] = 8'hA5;
    hdr[21:20] = 2'd2;
    hdr[18:16] = ch;
    hdr[9:0]   = d;
    step(1'b1, hdr);
    dly_m[ch] = d;
    chk("dly_val", delay_ca, dly_pack());
    chk("dly_wren", 80'(wren), 80'h0);
    chk("dly_err", 80'(err), 80'h0);
    chk("dly_busy", 80'(busy), 80'h0);
  endtask

  task automatic run_bad(input logic [31:0] hdr);
    step(1'b1, hdr);
    chk("bad_err", 80'(err), 80'h1);
    chk("bad_wren", 80'(wren), 80'h0);
    chk("bad_busy", 80'(busy), 80'h0);
    chk("bad_dly", delay_ca, dly_pack());
  endtask

  function automatic logic [31:0] rand_bad_hdr();
    logic [31:0] h;
    h = $urandom;
    if ($urandom_range(0, 1) == 1) begin
      h[31:24] = 8'hA5;
      h[21:20] = 2'd3;
    end else begin
      h[31:24] = 8'hA5 ^ 8'($urandom_range(1, 255));
    end
    return h;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) dly_m[i] = '0;
    last_data = '0;
    #1;
    chk("rst_wren", 80'(wren), 80'h0);
    chk("rst_data", 80'(data), 80'h0);
    chk("rst_busy", 80'(busy), 80'h0);
    chk("rst_dly", delay_ca, 80'h0);
    chk("rst_err", 80'(err), 80'h0);
    chk("rst_ready", 80'(s_ready), 80'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) dly_m[i] = '0;
    last_data = '0;
    s_valid = 1'b0;
    do_reset();
    idle_cycles(2);

    // CA channel 3, counting payload, no gaps.
    run_burst(1'b0, 3'd3, 0, 1'b1, 32);
    idle_cycles(1);
    // MSG channel 1 with s_valid toggling.
    run_burst(1'b1, 3'd1, 1, 1'b0, 47);
    // Delay set ch6 = 0x155 directly after a burst.
    run_delay(3'd6, 10'h155);
    // Bad sync then reserved command, back to back.
    run_bad(32'h5A00_0000);
    run_bad(32'hA530_0000);
    idle_cycles(1);

    // Reset in the middle of a CA burst, then a fresh complete burst.
    run_delay(3'd2, 10'h3C1);
    run_burst(1'b0, 3'd5, 0, 1'b0, 10);
    @(negedge clk);
    s_valid = 1'b0;
    do_reset();
    idle_cycles(1);
    run_burst(1'b0, 3'd5, 2, 1'b0, 32);

    // Random transaction sequences, including back-to-back headers.
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: run_burst(1'b0, 3'($urandom), 2, 1'b0, 32);
        1: run_burst(1'b1, 3'($urandom), 2, 1'b0, 47);
        2: run_delay(3'($urandom), 10'($urandom));
        default: run_bad(rand_bad_hdr());
      endcase
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end

`ifdef BB_LOADER_TIMEOUT_EN
    begin
      int  pads;
      bit  seen;
      run_burst(1'b0, 3'd0, 0, 1'b0, 5);
      seen = 1'b0;
      for (int k = 0; k < 70000 && !seen; k++) begin
        step(1'b0, $urandom);
        if (err) seen = 1'b1;
      end
      chk("to_err_seen", 80'(seen), 80'h1);
      chk("to_ready_low", 80'(s_ready), 80'h0);
      chk("to_wren_first", 80'(wren), 80'h0);
      pads = 0;
      for (int k = 0; k < 100 && busy; k++) begin
        step(1'b1, $urandom);
        if (wren != 16'h0) begin
          pads++;
          chk("pad_wren", 80'(wren), 80'h0001);
          chk("pad_data", 80'(data), 80'h0);
        end
      end
      chk("pad_count", 80'(pads), 80'd27);
      chk("pad_busy", 80'(busy), 80'h0);
      chk("pad_ready", 80'(s_ready), 80'h1);
      s_valid = 1'b0;
      last_data = '0;
      idle_cycles(1);
      run_burst(1'b1, 3'd7, 2, 1'b0, 47);
    end
`endif

    idle_cycles(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
